// File: rtl/async_trng_fifo.sv
// TRNG collector: samples ring outputs, XOR-folds and decimates them, packs words into a
// first-word fall-through FIFO, and guards the raw stream with a repetition-count test.
module async_trng_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned SRC_WIDTH = 5,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DECIM     = 1,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic [NSRC*SRC_WIDTH-1:0]   i_rnd_src,
  input  logic                        i_read,
  input  logic                        i_clr_alarm,
  output logic [WIDTH-1:0]            o_dat,
  output logic                        o_valid,
  output logic [$clog2(DEPTH):0]      o_level,
  output logic                        o_alarm,
  output logic [NSRC*SRC_WIDTH-1:0]   o_sampled
);

  localparam int unsigned NB = NSRC * SRC_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

  logic [NB-1:0]    r_sampled;
  logic             r_s_v, r_raw, r_r_v;
  logic             r_acc;
  logic [DW-1:0]    r_dcnt;
  logic [WIDTH-1:0] r_sh, w_sh_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic             r_last, r_alarm;
  logic [RW-1:0]    r_run;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;

  logic          w_bit_v, w_bit, w_trip, w_flush, w_full, w_pop, w_push;
  logic [RW-1:0] w_run_inc, w_run_nxt;

  assign w_bit_v   = r_r_v && (r_dcnt == DW'(DECIM - 1));
  assign w_bit     = r_acc ^ r_raw;
  assign w_run_inc = (r_run == RW'(RCT_LIMIT)) ? r_run : r_run + RW'(1);
  assign w_run_nxt = (r_raw == r_last) ? w_run_inc : RW'(1);
  // A clear in the same cycle wins over a trip, so no trip and no flush then.
  assign w_trip    = r_r_v && (w_run_nxt == RW'(RCT_LIMIT)) && !i_clr_alarm;
  // Assembly is held empty for as long as the alarm stands.
  assign w_flush   = w_trip || r_alarm;
  assign w_full    = (r_level == (AW + 1)'(DEPTH));
  assign w_pop     = i_read && o_valid;
  assign w_push    = (r_cnt == CW'(WIDTH)) && (!w_full || w_pop) && !w_flush;

  always_comb begin
    w_sh_d  = r_sh;
    w_cnt_d = r_cnt;
    if (w_flush) begin
      w_sh_d  = '0;
      w_cnt_d = '0;
    end else if (r_cnt == CW'(WIDTH)) begin
      if (w_push) begin
        w_sh_d  = w_bit_v ? WIDTH'(w_bit) : '0;
        w_cnt_d = w_bit_v ? CW'(1) : '0;
      end else if (w_bit_v) begin
        // Full FIFO: keep mixing new entropy into the pending word.
        w_sh_d = {r_sh[WIDTH-2:0], r_sh[WIDTH-1] ^ w_bit};
      end
    end else if (w_bit_v) begin
      w_sh_d  = {r_sh[WIDTH-2:0], w_bit};
      w_cnt_d = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sampled <= '0;
      r_s_v     <= 1'b0;
      r_raw     <= 1'b0;
      r_r_v     <= 1'b0;
      r_acc     <= 1'b0;
      r_dcnt    <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_run     <= '0;
      r_alarm   <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
    end else begin
      if (i_en) r_sampled <= i_rnd_src;
      r_s_v <= i_en;
      r_raw <= ^r_sampled;
      r_r_v <= r_s_v;
      r_sh  <= w_sh_d;
      r_cnt <= w_cnt_d;

      if (w_flush) begin
        r_acc  <= 1'b0;
        r_dcnt <= '0;
      end else if (r_r_v) begin
        r_acc  <= w_bit_v ? 1'b0 : w_bit;
        r_dcnt <= w_bit_v ? '0 : r_dcnt + DW'(1);
      end

      if (r_r_v) r_last <= r_raw;
      if (i_clr_alarm) begin
        r_run   <= '0;
        r_alarm <= 1'b0;
      end else if (r_r_v) begin
        r_run <= w_run_nxt;
        if (w_trip) r_alarm <= 1'b1;
      end

      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_push && !w_pop)      r_level <= r_level + (AW + 1)'(1);
        else if (w_pop && !w_push) r_level <= r_level - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= r_sh;
  end

  assign o_dat     = (r_level != '0) ? r_mem[r_rptr] : '0;
  assign o_valid   = (r_level != '0) && !r_alarm;
  assign o_level   = r_level;
  assign o_alarm   = r_alarm;
  assign o_sampled = r_sampled;

endmodule

// File: tb/tb_async_trng_fifo.sv
// Directed bench for async_trng_fifo: DECIM=1 instance for packing, full-FIFO fold, health
// alarm, enable gap and reset; a DECIM=2 instance for decimation.
module tb_async_trng_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, read1, clr1, en2;
  logic [9:0] src1, src2;
  logic [7:0] dat1, dat2;
  logic       valid1, valid2, alarm1, alarm2;
  logic [2:0] level1, level2;
  logic [9:0] samp1, samp2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  async_trng_fifo #(.DECIM(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_en(en1), .i_rnd_src(src1), .i_read(read1),
    .i_clr_alarm(clr1), .o_dat(dat1), .o_valid(valid1), .o_level(level1),
    .o_alarm(alarm1), .o_sampled(samp1)
  );

  async_trng_fifo #(.DECIM(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_en(en2), .i_rnd_src(src2), .i_read(1'b0),
    .i_clr_alarm(1'b0), .o_dat(dat2), .o_valid(valid2), .o_level(level2),
    .o_alarm(alarm2), .o_sampled(samp2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random ring pattern whose XOR parity equals p.
  function automatic logic [9:0] mk(input logic p);
    logic [9:0] v;
    v = 10'($urandom);
    v[0] = v[0] ^ (^v) ^ p;
    return v;
  endfunction

  task automatic feed1(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      en1  = 1'b1;
      src1 = mk(bits[i]);
      tick();
    end
    en1  = 1'b0;
    src1 = 10'($urandom);
  endtask

  task automatic feed2(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      en2  = 1'b1;
      src2 = mk(bits[i]);
      tick();
    end
    en2  = 1'b0;
    src2 = 10'($urandom);
  endtask

  task automatic pop1();
    read1 = 1'b1;
    tick();
    read1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b1; en2 = 1'b1; read1 = 1'b0; clr1 = 1'b0;
    src1 = 10'h3ff; src2 = 10'h155;

    // Reset with live inputs
    repeat (3) begin
      tick();
      src1 = 10'($urandom);
    end
    chk("rst_sampled", 32'(samp1), 32'h0);
    chk("rst_dat", 32'(dat1), 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_level", 32'(level1), 32'h0);
    chk("rst_alarm", 32'(alarm1), 32'h0);
    chk("rst_level2", 32'(level2), 32'h0);

    // Packing: first bit lands in the MSB, push on edge 10
    rst = 1'b0; en2 = 1'b0;
    feed1(64'hB2, 8);
    tick();
    tick();
    chk("pack_valid_e9", 32'(valid1), 32'h0);
    tick();
    chk("pack_valid_e10", 32'(valid1), 32'h1);
    chk("pack_level_e10", 32'(level1), 32'h1);
    chk("pack_dat", 32'(dat1), 32'hB2);
    pop1();
    chk("pop_level", 32'(level1), 32'h0);
    chk("pop_valid", 32'(valid1), 32'h0);
    chk("pop_dat", 32'(dat1), 32'h0);
    pop1();
    chk("pop_empty_ignored", 32'(level1), 32'h0);

    // Full FIFO: four words stored, fifth word 0x81 folded with bits 1,1 -> 0x05
    feed1({22'd0, 8'h5A, 8'h3C, 8'h96, 8'hC3, 8'h81, 2'b11}, 42);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("full_head_%0d", i), 32'(dat1), 32'h5A);
      chk($sformatf("full_level_%0d", i), 32'(level1), 32'h4);
    end
    pop1();
    chk("fold_level", 32'(level1), 32'h4);
    chk("fold_head1", 32'(dat1), 32'h3C);
    pop1();
    chk("fold_head2", 32'(dat1), 32'h96);
    pop1();
    chk("fold_head3", 32'(dat1), 32'hC3);
    chk("fold_level3", 32'(level1), 32'h2);
    pop1();
    chk("fold_word", 32'(dat1), 32'h05);
    pop1();
    chk("drain_level", 32'(level1), 32'h0);

    // Repetition count: 32 zeros trip on the 32nd raw bit (edge 33)
    feed1(64'h0, 32);
    tick();
    chk("rct_alarm_e32", 32'(alarm1), 32'h0);
    chk("rct_level_e32", 32'(level1), 32'h3);
    tick();
    chk("rct_alarm_e33", 32'(alarm1), 32'h1);
    chk("rct_level_e33", 32'(level1), 32'h0);
    chk("rct_valid_e33", 32'(valid1), 32'h0);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("clr_alarm", 32'(alarm1), 32'h0);
    chk("clr_valid", 32'(valid1), 32'h0);
    feed1(64'hA5, 8);
    tick();
    tick();
    tick();
    chk("restart_valid", 32'(valid1), 32'h1);
    chk("restart_dat", 32'(dat1), 32'hA5);
    pop1();
    chk("restart_pop", 32'(level1), 32'h0);

    // DECIM=2: raw 1101_1000_1110_0100 -> bits 0110_0110, push on edge 18
    feed2(64'hD8E4, 16);
    tick();
    tick();
    chk("dec2_valid_e17", 32'(valid2), 32'h0);
    tick();
    chk("dec2_valid_e18", 32'(valid2), 32'h1);
    chk("dec2_dat", 32'(dat2), 32'h66);
    chk("dec2_level", 32'(level2), 32'h1);

    // Enable gap of 5 cycles mid-word delays the push from edge 10 to 15
    feed1(64'hC, 4);
    repeat (5) begin
      src1 = 10'($urandom);
      tick();
    end
    feed1(64'h9, 4);
    tick();
    tick();
    chk("gap_level_e14", 32'(level1), 32'h0);
    tick();
    chk("gap_level_e15", 32'(level1), 32'h1);
    chk("gap_dat", 32'(dat1), 32'hC9);
    feed1(64'h1122, 16);
    repeat (3) tick();
    chk("pre_rst_level", 32'(level1), 32'h3);

    // Reset mid-operation
    rst = 1'b1;
    tick();
    chk("mid_rst_sampled", 32'(samp1), 32'h0);
    chk("mid_rst_dat", 32'(dat1), 32'h0);
    chk("mid_rst_valid", 32'(valid1), 32'h0);
    chk("mid_rst_level", 32'(level1), 32'h0);
    chk("mid_rst_alarm", 32'(alarm1), 32'h0);
    chk("mid_rst_level2", 32'(level2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
